// File: rtl/dcache_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dcache_arbiter
// Brief   : Shares the single-port data cache between the core and a debug port
// Revision: 1.0 - initial release
// ============================================================================
module dcache_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int STARVE = 4,
    parameter int BURST  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_stall_o,
    output logic [DW-1:0] core_rdata_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [0:0] S_CORE = 1'b0;
    localparam logic [0:0] S_DBG  = 1'b1;

    localparam int WW = $clog2(STARVE + 1);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE - 1);
    localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          core_win;
    logic          dbg_win;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_CORE;
            wait_q   <= '0;
            burst_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            burst_q  <= burst_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        if (state_q == S_CORE) begin
            burst_d = '0;
            if (dbg_req_i && core_req_i) begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_DBG;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end else begin
                wait_d = '0;
            end
        end else begin
            wait_d = '0;
            if (dbg_req_i) begin
                if (burst_q == BURST_LAST) begin
                    state_d = S_CORE;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + BURST_ONE;
                end
            end else begin
                // Debug went away early: core already owns this cycle.
                state_d = S_CORE;
                burst_d = '0;
            end
        end
        rvalid_d = dbg_win && !dbg_we_i;
        rdata_d  = rvalid_d ? mem_rdata_i : rdata_q;
    end

    always_comb begin
        core_win = 1'b0;
        dbg_win  = 1'b0;
        if (!rst_i) begin
            if (state_q == S_DBG && dbg_req_i) begin
                dbg_win = 1'b1;
            end else if (core_req_i) begin
                core_win = 1'b1;
            end else if (dbg_req_i) begin
                dbg_win = 1'b1;
            end
        end

        core_stall_o = core_req_i && !core_win && !rst_i;
        dbg_gnt_o    = dbg_win;
        mem_we_o     = (core_win && core_we_i) || (dbg_win && dbg_we_i);
        mem_re_o     = (core_win && !core_we_i) || (dbg_win && !dbg_we_i);
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        if (core_win) begin
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end else if (dbg_win) begin
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end
    end

    assign core_rdata_o = mem_rdata_i;
    assign dbg_rvalid_o = rvalid_q;
    assign dbg_rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: doc/dcache_arbiter.md
# dcache_arbiter

Two-requester arbiter that shares the single-port data cache between the core's memory-access stage and a debug/loader port (program upload, memory inspection). Sits between the core and the data cache. It muxes address, write data and enables, stalls the core when it loses arbitration, and returns registered read data to the debug port. A starvation counter plus a bounded debug burst guarantee forward progress for both requesters.

## Interface
- AW, 5: word-address width (cache index).
- DW, 32: data width.
- STARVE, 4: consecutive denied debug cycles before the debug port is forced priority; ≥1.
- BURST, 2: maximum consecutive debug grants while in forced priority; ≥1.

- clk_i, in, 1: clock, all state on rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- core_req_i, in, 1: core requests an access this cycle.
- core_we_i, in, 1: 1 = write, 0 = read.
- core_addr_i, in, AW: word address.
- core_wdata_i, in, DW: write data.
- core_stall_o, out, 1: core lost arbitration; hold PC and all state.
- core_rdata_o, out, DW: combinational read data, valid when core_req_i & !core_stall_o.
- dbg_req_i, in, 1: debug requests an access; held until granted.
- dbg_we_i, in, 1: 1 = write.
- dbg_addr_i, in, AW: word address.
- dbg_wdata_i, in, DW: write data.
- dbg_gnt_o, out, 1: debug access performed this cycle (combinational).
- dbg_rvalid_o, out, 1: one-cycle pulse, registered read data valid.
- dbg_rdata_o, out, DW: registered read data, held until next debug read completes.
- mem_we_o, out, 1: cache write enable.
- mem_re_o, out, 1: cache read enable.
- mem_addr_o, out, AW: cache address.
- mem_wdata_o, out, DW: cache write data.
- mem_rdata_i, in, DW: cache read data, combinational from mem_addr_o.

## Operation
- Winner each cycle is combinational from state and requests. Only the winner's address, data and enables reach the cache. With no winner: mem_we_o = mem_re_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- mem_re_o = winner & !we; mem_we_o = winner & we.
- core_stall_o = core_req_i & winner≠core. dbg_gnt_o = winner = dbg.
- core_rdata_o = mem_rdata_i, always passed through.
- State S_CORE (reset state):
  - core_req_i wins if high. Otherwise dbg_req_i wins.
  - wait_cnt increments when dbg_req_i & core_req_i. It clears when debug is granted or dbg_req_i is low.
  - A denial with wait_cnt = STARVE-1 moves the FSM to S_DBG and clears wait_cnt.
- State S_DBG:
  - dbg_req_i wins unconditionally and burst_cnt increments.
  - If dbg_req_i is low, the core wins in the same cycle (no dead cycle) and the FSM returns to S_CORE.
  - The grant with burst_cnt = BURST-1 returns the FSM to S_CORE next cycle and clears burst_cnt.
- Debug read grant: mem_rdata_i is captured into dbg_rdata_o at the edge, and dbg_rvalid_o pulses the next cycle.
- Debug write grant: no rvalid. The cache writes at the edge.
- Counter widths are $clog2 of parameter+1. Counters never wrap because they saturate at their thresholds.

## Timing
- Reset values: state S_CORE, wait_cnt = 0, burst_cnt = 0, dbg_rvalid_o = 0, dbg_rdata_o = 0.
- While rst_i is high, all combinational outputs are forced to 0: stall, gnt, mem_we_o, mem_re_o, address and write data. No cache write occurs during reset.
- Reset mid-burst aborts the burst. An in-flight debug read loses its rvalid.
- Core access latency: 0 cycles when granted. Stall covers at most BURST consecutive cycles per starvation event.
- Debug worst-case wait with the core continuously requesting: STARVE cycles denied, granted on cycle STARVE+1.
- Handshake: debug must hold req/we/addr/wdata stable until dbg_gnt_o. Changes while not granted are allowed but undefined for the abandoned request.
- Simultaneous requests to the same address: only the winner accesses; the loser retries next cycle and sees the updated data.

## Test plan
- Reset: assert rst_i with both requests high and core_we_i = 1 -> mem_we_o = 0, core_stall_o = 0, dbg_rvalid_o = 0. After release, state is S_CORE.
- Idle-core debug write then read: dbg write 0xDEADBEEF at address 3 (granted the same cycle), then a read of address 3 -> dbg_rvalid_o pulses one cycle after the read grant with dbg_rdata_o = 0xDEADBEEF.
- Core priority: both request, debug not starved -> core_stall_o = 0 and dbg_gnt_o = 0 for 4 cycles. On cycle 5 dbg_gnt_o = 1 and core_stall_o = 1 (STARVE=4).
- Burst bound: continuous requests from both with BURST=2 -> pattern repeats as 4 core grants, 2 debug grants, with exactly 2 consecutive stalled core cycles per period.
- Early burst exit: in S_DBG, drop dbg_req_i after 1 grant -> the core is granted that same cycle (core_stall_o = 0) and the state returns to S_CORE.
- Reset mid-burst: assert rst_i during the 1st debug read grant in S_DBG -> no dbg_rvalid_o pulse and no mem_we_o. After release the core is granted first.
